// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient reconfiguration sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StFlush,
    StRun,
    StDrain
  } fir_state_e;

  localparam int unsigned DefDataWidth = 24;
  localparam int unsigned DefFirDepth  = 128;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_sequencer_if.sv
// Control/status and coefficient-write bundle between the sequencer and the FIR datapath side.
interface fir_coeff_sequencer_if
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_W     = addr_width(DefFirDepth)
) ();

  logic                  i_en;
  logic                  i_load_req;
  logic [DATA_WIDTH-1:0] iv_coef;
  logic                  i_coef_valid;
  logic                  o_coef_ready;
  logic                  i_dp_idle;
  logic                  o_dp_en;
  logic                  o_in_hold;
  logic                  o_dp_clr;
  logic                  o_coef_we;
  logic [ADDR_W-1:0]     ov_coef_addr;
  logic [DATA_WIDTH-1:0] ov_coef_data;
  logic                  o_busy;
  logic                  o_cfg_done;
  logic                  o_err;

  modport master (
    input  i_en, i_load_req, iv_coef, i_coef_valid, i_dp_idle,
    output o_coef_ready, o_dp_en, o_in_hold, o_dp_clr, o_coef_we,
    output ov_coef_addr, ov_coef_data, o_busy, o_cfg_done, o_err
  );

  modport slave (
    output i_en, i_load_req, iv_coef, i_coef_valid, i_dp_idle,
    input  o_coef_ready, o_dp_en, o_in_hold, o_dp_clr, o_coef_we,
    input  ov_coef_addr, ov_coef_data, o_busy, o_cfg_done, o_err
  );

endinterface

// File: rtl/fir_timeout_counter.sv
// Up-counter with synchronous clear and terminal-count flag at Limit-1.
module fir_timeout_counter #(
  parameter int unsigned Limit = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/fir_coeff_sequencer.sv
// Sequences FIR reconfiguration: drain in-flight samples, load the coefficient bank,
// clear the delay line, then release the datapath.
module fir_coeff_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned FIR_DEPTH     = DefFirDepth,
  parameter int unsigned ADDR_W        = addr_width(FIR_DEPTH),
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  fir_coeff_sequencer_if.master bus
);

  fir_state_e state_q, state_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic dp_en_q, dp_en_d;
  logic in_hold_q, in_hold_d;
  logic dp_clr_q, dp_clr_d;
  logic we_q, we_d;
  logic busy_q, busy_d;
  logic cfg_done_q, cfg_done_d;
  logic err_q, err_d;

  logic coef_ready, hs, timeout;
  logic flush_step, flush_tc, drain_step, drain_tc;

  assign coef_ready = (state_q == StLoad) & bus.i_en;
  assign hs         = bus.i_coef_valid & coef_ready;
  assign flush_step = bus.i_en & (state_q == StFlush);
  assign drain_step = bus.i_en & (state_q == StDrain);

  // FLUSH occupies FLUSH_CYCLES cycles including the clear cycle.
  fir_timeout_counter #(
    .Limit (FLUSH_CYCLES)
  ) u_flush_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .step_i (flush_step),
    .clr_i  (flush_step & flush_tc),
    .tc_o   (flush_tc)
  );

  fir_timeout_counter #(
    .Limit (DRAIN_TIMEOUT)
  ) u_drain_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .step_i (drain_step),
    .clr_i  (drain_step & (bus.i_dp_idle | drain_tc)),
    .tc_o   (drain_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (bus.i_en) begin
      unique case (state_q)
        StLoad: begin
          if (hs) begin
            if (cnt_q == ADDR_W'(FIR_DEPTH - 1)) begin
              cnt_d   = '0;
              state_d = StFlush;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        StFlush: if (flush_tc) state_d = StRun;
        StRun:   if (bus.i_load_req) state_d = StDrain;
        StDrain: begin
          // Idle wins over a coincident timeout.
          if (bus.i_dp_idle) begin
            state_d = StLoad;
          end else if (drain_tc) begin
            state_d = StLoad;
            timeout = 1'b1;
          end
        end
        default: state_d = StLoad;
      endcase
    end
  end

  // Registered outputs follow the next state; strobes drop while frozen.
  always_comb begin
    dp_en_d    = dp_en_q;
    in_hold_d  = in_hold_q;
    busy_d     = busy_q;
    cfg_done_d = cfg_done_q;
    err_d      = err_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dp_clr_d   = 1'b0;
    we_d       = 1'b0;
    if (bus.i_en) begin
      dp_en_d    = (state_d != StLoad);
      in_hold_d  = (state_d != StRun);
      busy_d     = (state_d != StRun);
      dp_clr_d   = (state_q == StLoad) && (state_d == StFlush);
      cfg_done_d = (state_q == StFlush) && (state_d == StRun);
      err_d      = err_q | timeout;
      we_d       = hs;
      if (hs) begin
        addr_d = cnt_q;
        data_d = bus.iv_coef;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StLoad;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      dp_en_q    <= 1'b0;
      in_hold_q  <= 1'b1;
      dp_clr_q   <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b1;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dp_en_q    <= dp_en_d;
      in_hold_q  <= in_hold_d;
      dp_clr_q   <= dp_clr_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
    end
  end

  assign bus.o_coef_ready = coef_ready;
  assign bus.o_dp_en      = dp_en_q;
  assign bus.o_in_hold    = in_hold_q;
  assign bus.o_dp_clr     = dp_clr_q;
  assign bus.o_coef_we    = we_q;
  assign bus.ov_coef_addr = addr_q;
  assign bus.ov_coef_data = data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_cfg_done   = cfg_done_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_fir_coeff_sequencer.sv
// Randomized bench for fir_coeff_sequencer against a phase-level reference model.
module tb_fir_coeff_sequencer;

  localparam int unsigned DW            = 24;
  localparam int unsigned DEPTH         = 128;
  localparam int unsigned AW            = 7;
  localparam int unsigned FLUSH_CYCLES  = 4;
  localparam int unsigned DRAIN_TIMEOUT = 1024;

  localparam int PhLoad  = 0;
  localparam int PhFlush = 1;
  localparam int PhRun   = 2;
  localparam int PhDrain = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fir_coeff_sequencer_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  fir_coeff_sequencer #(
    .DATA_WIDTH    (DW),
    .FIR_DEPTH     (DEPTH),
    .ADDR_W        (AW),
    .FLUSH_CYCLES  (FLUSH_CYCLES),
    .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int wr_count = 0;

  // Reference model: phase, words accepted, remaining flush cycles, drain age.
  int m_phase, m_words, m_flush_left, m_drain_age;
  bit m_err;
  bit e_we, e_clr, e_done, e_dp_en, e_hold, e_busy;
  int e_addr, e_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = PhLoad; m_words = 0; m_flush_left = 0; m_drain_age = 0; m_err = 0;
    e_we = 0; e_clr = 0; e_done = 0; e_dp_en = 0; e_hold = 1; e_busy = 1;
    e_addr = 0; e_data = 0;
  endtask

  task automatic model_step();
    if (!bus.i_en) begin
      e_we = 0;
      e_clr = 0;
      return;
    end
    e_we = 0; e_clr = 0; e_done = 0;
    case (m_phase)
      PhLoad: if (bus.i_coef_valid) begin
        e_we = 1; e_addr = m_words; e_data = int'(bus.iv_coef);
        m_words++;
        if (m_words == DEPTH) begin
          m_words = 0; m_phase = PhFlush; m_flush_left = FLUSH_CYCLES; e_clr = 1;
        end
      end
      PhFlush: begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_phase = PhRun; e_done = 1;
        end
      end
      PhRun: if (bus.i_load_req) begin
        m_phase = PhDrain; m_drain_age = 0;
      end
      default: begin
        m_drain_age++;
        if (bus.i_dp_idle) m_phase = PhLoad;
        else if (m_drain_age == DRAIN_TIMEOUT) begin
          m_err = 1; m_phase = PhLoad;
        end
      end
    endcase
    e_dp_en = (m_phase != PhLoad);
    e_hold  = (m_phase != PhRun);
    e_busy  = e_hold;
  endtask

  task automatic check_outputs();
    check_eq("we", bus.o_coef_we, e_we);
    if (e_we) begin
      check_eq("addr", bus.ov_coef_addr, e_addr);
      check_eq("data", bus.ov_coef_data, e_data);
    end
    check_eq("clr", bus.o_dp_clr, e_clr);
    check_eq("cfg_done", bus.o_cfg_done, e_done);
    check_eq("dp_en", bus.o_dp_en, e_dp_en);
    check_eq("in_hold", bus.o_in_hold, e_hold);
    check_eq("busy", bus.o_busy, e_busy);
    check_eq("err", bus.o_err, m_err);
    // Independent of the model: writes within a load must walk 0,1,2,...
    if (bus.o_coef_we) begin
      check_eq("wr_seq", bus.ov_coef_addr, wr_count % DEPTH);
      wr_count++;
    end
  endtask

  task automatic set_inputs(input bit en, input bit valid, input logic [DW-1:0] coef,
                            input bit req, input bit idle);
    bus.i_en = en; bus.i_coef_valid = valid; bus.iv_coef = coef;
    bus.i_load_req = req; bus.i_dp_idle = idle;
    #1;
    check_eq("ready", bus.o_coef_ready, (m_phase == PhLoad) && en);
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_dp_en", bus.o_dp_en, 0);
    check_eq("rst_hold", bus.o_in_hold, 1);
    check_eq("rst_clr", bus.o_dp_clr, 0);
    check_eq("rst_we", bus.o_coef_we, 0);
    check_eq("rst_addr", bus.ov_coef_addr, 0);
    check_eq("rst_data", bus.ov_coef_data, 0);
    check_eq("rst_busy", bus.o_busy, 1);
    check_eq("rst_done", bus.o_cfg_done, 0);
    check_eq("rst_err", bus.o_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_count = 0;
  endtask

  task automatic do_load(input bit rnd, input bit req, input int gap_at, input int rst_at);
    int start, n_clr, clr_cyc, done_cyc, gap_we;
    bit gap_done, vld;
    logic [DW-1:0] cf;
    start = wr_count; n_clr = 0; clr_cyc = -1; done_cyc = -1; gap_done = 0;
    for (int c = 0; c < 4000 && m_phase != PhRun; c++) begin
      if (rst_at >= 0 && m_phase == PhLoad && m_words == rst_at) begin
        apply_reset();
        return;
      end
      if (gap_at >= 0 && !gap_done && m_phase == PhLoad && m_words == gap_at) begin
        gap_we = 0;
        for (int g = 0; g < 5; g++) begin
          set_inputs(1'b0, 1'b1, DW'($urandom), req, 1'b0);
          cycle();
          gap_we += int'(bus.o_coef_we);
        end
        check_eq("gap_we", gap_we, 0);
        gap_done = 1;
      end
      vld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cf  = rnd ? DW'($urandom) : DW'(m_words + 'h100);
      set_inputs(1'b1, vld, cf, req, 1'b0);
      cycle();
      if (bus.o_dp_clr) begin
        n_clr++;
        clr_cyc = cyc;
      end
      if (bus.o_cfg_done) done_cyc = cyc;
    end
    check_eq("load_busy", bus.o_busy, 0);
    check_eq("n_writes", wr_count - start, DEPTH);
    check_eq("n_clr", n_clr, 1);
    check_eq("clr_to_done", done_cyc - clr_cyc, FLUSH_CYCLES);
    check_eq("hold_run", bus.o_in_hold, 0);
  endtask

  initial begin
    int n;
    bus.i_en = 1'b1; bus.i_coef_valid = 1'b0; bus.iv_coef = '0;
    bus.i_load_req = 1'b0; bus.i_dp_idle = 1'b0;
    model_reset();
    #2;
    apply_reset();

    do_load(1'b0, 1'b0, -1, -1);
    repeat (3) begin
      set_inputs(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cycle();
    end

    // Drain that ends on idle after 10 busy cycles.
    set_inputs(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    check_eq("drain_hold", bus.o_in_hold, 1);
    check_eq("drain_dp_en", bus.o_dp_en, 1);
    repeat (10) begin
      set_inputs(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cycle();
    end
    set_inputs(1'b1, 1'b0, '0, 1'b0, 1'b1);
    cycle();
    check_eq("idle_to_load", bus.o_dp_en, 0);
    check_eq("err_idle", bus.o_err, 0);

    // Random-valid load with the request held: DRAIN right after cfg_done, then timeout.
    do_load(1'b1, 1'b1, -1, -1);
    set_inputs(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle();
    check_eq("req_held_drain", bus.o_in_hold & bus.o_dp_en, 1);
    n = 0;
    while (n < 2000 && bus.o_in_hold && bus.o_dp_en) begin
      n++;
      set_inputs(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cycle();
    end
    check_eq("drain_len", n, DRAIN_TIMEOUT);
    check_eq("err_set", bus.o_err, 1);

    do_load(1'b0, 1'b0, 60, -1);
    check_eq("err_sticky", bus.o_err, 1);

    set_inputs(1'b1, 1'b0, '0, 1'b1, 1'b1);
    cycle();
    set_inputs(1'b1, 1'b0, '0, 1'b0, 1'b1);
    cycle();
    check_eq("back_to_load", bus.o_dp_en, 0);

    do_load(1'b1, 1'b0, -1, 90);
    do_load(1'b1, 1'b0, -1, -1);
    check_eq("err_after_rst", bus.o_err, 0);
    repeat (2) begin
      set_inputs(1'b1, 1'b0, '0, 1'b0, 1'b0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
